stopwatch_bcd_counter: RTL and testbench
========================================

# stopwatch_bcd_counter

Parametrised multi-digit BCD counter for the stopwatch datapath, replacing the fixed units/tens ripple pair with a fully synchronous cascade. It provides a start/stop state machine, up/down counting, synchronous clear and load, and a wrap carry for chaining stages (seconds → minutes). An optional lap-hold display freeze is available. It sits between the tick prescaler and the 7-segment decoders.

## Interface
- DIGITS, 2, number of BCD digits (≥1); digit 0 is least significant.
- TOP_MOD, 6, modulus of the most significant digit (2..10); all lower digits are mod 10.
- clk  in  1  system clock, rising edge.
- p  in  1  reset, asynchronous, active-high.
- tick  in  1  count enable pulse, one clk cycle wide.
- ss  in  1  start/stop pulse; toggles run state.
- up  in  1  direction: 1 counts up, 0 counts down.
- clr  in  1  synchronous clear to zero.
- load  in  1  synchronous load of load_val.
- load_val  in  4*DIGITS  BCD value to load.
- lap  in  1  lap pulse; used only with LAP_HOLD_EN.
- bcd  out  4*DIGITS  live count, registered.
- disp  out  4*DIGITS  value for display.
- running  out  1  1 in RUN state.
- carry  out  1  one-cycle pulse after a wrap in either direction.
- zero  out  1  combinational; 1 when bcd is all zero.

## Operation
- FSM states: STOP (reset state) and RUN. An ss pulse toggles the state at the clock edge. running = (state == RUN).
- Priority at each edge: clr > load > count. clr and load act in both states.
- Count condition: state == RUN and tick. ss has no effect on whether the current cycle counts.
- Up count:
  - digit 0 increments;
  - digit i steps only when all lower digits are at 9;
  - a digit at its max (9, or TOP_MOD-1 for the top digit) wraps to 0.
- Down count:
  - digit 0 decrements;
  - digit i steps only when all lower digits are 0;
  - a digit at 0 wraps to its max.
- Full wrap occurs at max→0 when counting up, or 0→max when counting down. carry is registered high for exactly the next cycle; otherwise it is 0.
- Load: each digit is checked independently. A digit greater than its max loads as 0; valid digits load unchanged. A load never produces a carry.
- clr: bcd = 0, carry = 0. The FSM state is unchanged.
- disp equals bcd unless lap-hold is active (see Configuration).

## Timing
- Reset (p=1) takes effect immediately. Values while reset is asserted:
  - bcd = 0, disp = 0, carry = 0, running = 0, state STOP;
  - lap hold cleared; zero = 1.
- Reset mid-count abandons the operation in progress. The first count after release needs tick while in RUN.
- Latency: bcd updates on the same edge that samples tick; carry is one cycle after that edge.
- ss and tick in the same cycle: the count uses the old state. RUN→STOP with tick counts once; STOP→RUN with tick does not count.
- ss held high toggles the state every cycle; callers must supply single-cycle pulses.
- tick, ss, and lap are sampled synchronously. No internal edge detection.

## Configuration
- LAP_HOLD_EN defined:
  - a lap pulse while not held captures the pre-edge bcd into a lap register and sets hold;
  - while held, disp shows the lap register and bcd keeps counting;
  - the next lap pulse clears hold, so disp returns to bcd;
  - clr and load also clear hold.
- LAP_HOLD_EN undefined: lap is ignored, no lap register is built, and disp = bcd permanently.

## Test plan
- Default parameters, sequence: p pulse, ss, then 60 ticks. Required response: bcd steps 0x00 → 0x59 → 0x00, carry high for one cycle after the wrap, running = 1.
- up=0 from 0x00 with one tick in RUN. Required response: bcd = 0x59, carry pulse. A further tick gives 0x58 with no carry.
- load with load_val = 0x4A, then 0x7 in the top digit. Required response: 0x4A loads as 0x40; top digit 0x7 loads as 0, since it exceeds TOP_MOD-1. clr+load+tick in the same cycle gives 0x00.
- In RUN, ss+tick together at bcd = 0x12. Required response: bcd = 0x13, then STOP, and further ticks leave 0x13. Then ss+tick together from STOP: still 0x13.
- p asserted mid-run at 0x37. Required response: immediately bcd = 0, running = 0, zero = 1. After release, ticks are ignored until ss.
- With LAP_HOLD_EN, lap at 0x21 then 5 ticks. Required response: disp = 0x21 and bcd = 0x26. A second lap gives disp = 0x26.

Source files
------------

// File: rtl/stopwatch_bcd_counter_if.sv
// stopwatch_bcd_counter_if -- control/data bundle for the stopwatch BCD counter.
//   master: drives tick, ss, up, clr, load, load_val, lap; observes the outputs.
//   slave : the counter; returns bcd (live), disp (display), running, carry, zero.
// DIGITS must match the counter instance it is bound to.
interface stopwatch_bcd_counter_if #(
    parameter int DIGITS = 2
);
    logic                  tick;
    logic                  ss;
    logic                  up;
    logic                  clr;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  lap;
    logic [4*DIGITS-1:0]   bcd;
    logic [4*DIGITS-1:0]   disp;
    logic                  running;
    logic                  carry;
    logic                  zero;

    modport master (
        output tick, ss, up, clr, load, load_val, lap,
        input  bcd, disp, running, carry, zero
    );

    modport slave (
        input  tick, ss, up, clr, load, load_val, lap,
        output bcd, disp, running, carry, zero
    );
endinterface

// File: rtl/stopwatch_bcd_counter.sv
// stopwatch_bcd_counter -- synchronous multi-digit BCD counter with start/stop FSM.
//   clk : rising-edge clock
//   p   : asynchronous active-high reset
//   bus : stopwatch_bcd_counter_if.slave (tick/ss/up/clr/load/load_val/lap in,
//         bcd/disp/running/carry/zero out)
// Parameters: DIGITS (>=1, digit 0 least significant), TOP_MOD (2..10, modulus
// of the top digit; lower digits are mod 10).
// Optional feature: define LAP_HOLD_EN to build the lap register that freezes
// disp while bcd keeps counting. Without it, lap is ignored and disp = bcd.
module stopwatch_bcd_counter #(
    parameter int DIGITS  = 2,
    parameter int TOP_MOD = 6
) (
    input  logic                    clk,
    input  logic                    p,
    stopwatch_bcd_counter_if.slave  bus
);
    localparam logic [3:0] TOP_MAX = 4'(TOP_MOD - 1);

    typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_t;

    state_t                  state, state_nxt;
    logic [DIGITS-1:0][3:0]  d_q, d_nxt, ld_fix;
    logic                    carry_q;
    logic                    count_en;
    logic                    wrap;
    logic                    step;

    function automatic logic [3:0] dmax(input int i);
        return (i == DIGITS - 1) ? TOP_MAX : 4'd9;
    endfunction

    // ---------------- start/stop FSM ----------------
    always_ff @(posedge clk or posedge p) begin
        if (p) state <= STOP;
        else   state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.ss) state_nxt = (state == RUN) ? STOP : RUN;
    end

    // Counting uses the pre-edge state, so ss+tick in the same cycle counts
    // only when leaving RUN.
    assign count_en = (state == RUN) && bus.tick;

    // ---------------- digit cascade ----------------
    // step is the running AND of "all lower digits at their limit"; after the
    // loop it means every digit was at its limit, i.e. a full wrap.
    always_comb begin
        d_nxt  = d_q;
        ld_fix = '0;
        step   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (count_en && step) begin
                if (bus.up) d_nxt[i] = (d_q[i] == dmax(i)) ? 4'd0 : d_q[i] + 4'd1;
                else        d_nxt[i] = (d_q[i] == 4'd0) ? dmax(i) : d_q[i] - 4'd1;
            end
            step = step && (bus.up ? (d_q[i] == dmax(i)) : (d_q[i] == 4'd0));
            // Out-of-range load digits collapse to zero, each digit on its own.
            ld_fix[i] = (bus.load_val[4*i +: 4] > dmax(i)) ? 4'd0 : bus.load_val[4*i +: 4];
        end
    end

    assign wrap = count_en && step;

    always_ff @(posedge clk or posedge p) begin
        if (p) begin
            d_q     <= '0;
            carry_q <= 1'b0;
        end else if (bus.clr) begin
            d_q     <= '0;
            carry_q <= 1'b0;
        end else if (bus.load) begin
            d_q     <= ld_fix;
            carry_q <= 1'b0;
        end else begin
            d_q     <= d_nxt;
            carry_q <= wrap;
        end
    end

    assign bus.bcd     = d_q;
    assign bus.carry   = carry_q;
    assign bus.running = (state == RUN);
    assign bus.zero    = (d_q == '0);

    // ---------------- lap hold ----------------
`ifdef LAP_HOLD_EN
    logic                    hold;
    logic [4*DIGITS-1:0]     lap_q;

    always_ff @(posedge clk or posedge p) begin
        if (p) begin
            hold  <= 1'b0;
            lap_q <= '0;
        end else if (bus.clr || bus.load) begin
            hold  <= 1'b0;
        end else if (bus.lap) begin
            if (hold) begin
                hold  <= 1'b0;
            end else begin
                hold  <= 1'b1;
                lap_q <= d_q;   // pre-edge value
            end
        end
    end

    assign bus.disp = hold ? lap_q : d_q;
`else
    logic unused_lap;
    assign unused_lap = bus.lap;
    assign bus.disp   = d_q;
`endif
endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// tb_stopwatch_bcd_counter -- directed self-checking bench for stopwatch_bcd_counter
// (DIGITS=2, TOP_MOD=6). Inputs change on the falling edge; outputs are checked
// on the falling edge after each rising edge.
module tb_stopwatch_bcd_counter;
    logic clk = 1'b0;
    logic p;
    int   ncmp = 0;
    int   nerr = 0;

    stopwatch_bcd_counter_if #(.DIGITS(2)) bus ();

    stopwatch_bcd_counter #(.DIGITS(2), .TOP_MOD(6)) dut (
        .clk (clk),
        .p   (p),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    initial begin
        p = 1'b1;
        bus.tick = 0; bus.ss = 0; bus.up = 1; bus.clr = 0;
        bus.load = 0; bus.load_val = '0; bus.lap = 0;
        #1;
        chk("rst_bcd",     bus.bcd, 8'h00);
        chk("rst_disp",    bus.disp, 8'h00);
        chk("rst_carry",   bus.carry, 0);
        chk("rst_running", bus.running, 0);
        chk("rst_zero",    bus.zero, 1);
        @(negedge clk);
        p = 1'b0;

        // start, then 60 up-ticks: full 00..59..00 sweep
        bus.ss = 1; cyc(); bus.ss = 0;
        chk("start_running", bus.running, 1);
        bus.tick = 1;
        for (int k = 1; k <= 60; k++) begin
            cyc();
            chk($sformatf("up_bcd_%0d", k), bus.bcd, to_bcd(k % 60));
            chk($sformatf("up_carry_%0d", k), bus.carry, (k == 60) ? 1 : 0);
        end
        bus.tick = 0; cyc();
        chk("carry_drop", bus.carry, 0);
        chk("zero_after_wrap", bus.zero, 1);

        // down from 00: wrap to 59 with carry, then 58 without
        bus.up = 0; bus.tick = 1; cyc();
        chk("dn_wrap_bcd", bus.bcd, 8'h59);
        chk("dn_wrap_carry", bus.carry, 1);
        chk("dn_zero", bus.zero, 0);
        cyc();
        chk("dn_bcd", bus.bcd, 8'h58);
        chk("dn_carry", bus.carry, 0);
        bus.tick = 0;

        // borrow across digit
        bus.load = 1; bus.load_val = 8'h30; cyc(); bus.load = 0;
        bus.tick = 1; cyc(); bus.tick = 0;
        chk("dn_borrow", bus.bcd, 8'h29);
        bus.up = 1;

        // load sanitising
        bus.load = 1; bus.load_val = 8'h4A; cyc();
        chk("load_4A", bus.bcd, 8'h40);
        chk("load_carry", bus.carry, 0);
        bus.load_val = 8'h75; cyc();
        chk("load_75", bus.bcd, 8'h05);
        bus.load_val = 8'h59; bus.tick = 1; cyc();
        chk("load_over_tick", bus.bcd, 8'h59);
        chk("load_no_carry", bus.carry, 0);
        bus.clr = 1; bus.load_val = 8'h22; cyc();
        chk("clr_load_tick", bus.bcd, 8'h00);
        chk("clr_keeps_run", bus.running, 1);
        bus.clr = 0; bus.load = 0; bus.tick = 0;

        // ss+tick together
        bus.load = 1; bus.load_val = 8'h12; cyc(); bus.load = 0;
        bus.ss = 1; bus.tick = 1; cyc(); bus.ss = 0;
        chk("ss_tick_run_bcd", bus.bcd, 8'h13);
        chk("ss_tick_run_state", bus.running, 0);
        cyc(3);
        chk("stop_ignores_tick", bus.bcd, 8'h13);
        bus.ss = 1; cyc(); bus.ss = 0;
        chk("ss_tick_stop_bcd", bus.bcd, 8'h13);
        chk("ss_tick_stop_state", bus.running, 1);
        cyc();
        chk("run_again", bus.bcd, 8'h14);
        bus.tick = 0;

        // asynchronous reset mid-run
        bus.load = 1; bus.load_val = 8'h37; cyc(); bus.load = 0;
        chk("pre_rst_bcd", bus.bcd, 8'h37);
        bus.tick = 1;
        #1 p = 1'b1;
        #1;
        chk("async_rst_bcd", bus.bcd, 8'h00);
        chk("async_rst_running", bus.running, 0);
        chk("async_rst_zero", bus.zero, 1);
        @(negedge clk);
        p = 1'b0;
        cyc(3);
        chk("post_rst_idle", bus.bcd, 8'h00);
        bus.tick = 0;
        bus.ss = 1; cyc(); bus.ss = 0;
        bus.tick = 1; cyc(); bus.tick = 0;
        chk("post_rst_count", bus.bcd, 8'h01);

        // lap behaviour
        bus.load = 1; bus.load_val = 8'h21; cyc(); bus.load = 0;
        bus.lap = 1; cyc(); bus.lap = 0;
        bus.tick = 1; cyc(5); bus.tick = 0;
        chk("lap_bcd", bus.bcd, 8'h26);
`ifdef LAP_HOLD_EN
        chk("lap_disp_held", bus.disp, 8'h21);
        bus.lap = 1; cyc(); bus.lap = 0;
        chk("lap_disp_release", bus.disp, 8'h26);
        bus.lap = 1; cyc(); bus.lap = 0;
        bus.tick = 1; cyc(); bus.tick = 0;
        chk("lap_held_again", bus.disp, 8'h26);
        bus.clr = 1; cyc(); bus.clr = 0;
        chk("clr_drops_hold", bus.disp, 8'h00);
`else
        chk("lap_ignored", bus.disp, 8'h26);
        bus.tick = 1; cyc(); bus.tick = 0;
        chk("disp_follows", bus.disp, 8'h27);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
